mul_sequencer: RTL
==================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Parameter: CNT_W, 5, iteration counter width; SHALL equal clog2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Is_Mul  input  1  EXE-stage instruction is MUL; acts as the start request.
REQ-006 flush  input  1  branch/jump flush; aborts any operation in progress.
REQ-007 val1  input  WIDTH  multiplicand from the EXE-stage operand mux.
REQ-008 val2  input  WIDTH  multiplier from the EXE-stage operand mux.
REQ-009 freeze  output  1  stalls PC, IF/ID, ID/EXE and EXE/MEM; also forces hazard_detected into the controller.
REQ-010 mul_result  output  WIDTH  low WIDTH bits of val1*val2.
REQ-011 result_valid  output  1  one-cycle strobe; mul_result is valid for EXE/MEM capture.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 IDLE: when Is_Mul=1 and flush=0, the block SHALL latch val1 and val2, clear the accumulator, set the counter to 0 and go to BUSY.
REQ-014 BUSY: each cycle the block SHALL add the shifted multiplicand to the accumulator if the current multiplier LSB is 1, shift the multiplicand left, shift the multiplier right and increment the counter.
REQ-015 BUSY: after WIDTH iterations (counter = WIDTH-1 processed), the FSM SHALL go to DONE.
REQ-016 DONE: result_valid SHALL be 1 for one cycle, then the FSM SHALL go to IDLE unconditionally.
REQ-017 Latency: Is_Mul is sampled in IDLE at cycle T and result_valid=1 at cycle T+WIDTH+1 (T+33 for WIDTH=32).
REQ-018 freeze SHALL be combinationally 1 in IDLE when Is_Mul=1 and flush=0, 1 throughout BUSY, and 0 in DONE, so the pipeline advances on the DONE edge.
REQ-019 Is_Mul in BUSY or DONE SHALL be ignored; no re-latching or restart occurs.
REQ-020 Back-to-back MULs: a new Is_Mul in the IDLE cycle immediately after DONE SHALL start a new operation with identical latency.
REQ-021 flush=1 in any state SHALL force IDLE on the next edge; freeze SHALL be 0 in that same cycle and no result_valid SHALL follow.
REQ-022 flush has priority over Is_Mul; simultaneous flush and Is_Mul in IDLE SHALL NOT start an operation.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH, so the low bits are identical for signed and unsigned operands, and overflow is discarded silently.
REQ-024 mul_result SHALL hold its last value until the next operation completes; it SHALL update only on entry to DONE.
REQ-025 Operand changes on val1 and val2 after the latch cycle SHALL NOT affect the result.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, counter=0, accumulator=0, operand registers=0 and mul_result=0, without waiting for a clock edge.
REQ-027 During reset, freeze=0 and result_valid=0 SHALL hold regardless of Is_Mul.
REQ-028 Reset during BUSY SHALL abandon the operation; the first Is_Mul after reset release SHALL start a fresh operation with full latency.

Structure
REQ-029 The state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and MUL_WIDTH SHALL live in the shared defines.v beside the OP_ and EXE_ codes.
REQ-030 The shift-add datapath (operand shift registers, accumulator, adder) SHALL be one sub-module, mul_shift_add_dp.
REQ-031 The FSM and counter SHALL stay in mul_sequencer.
REQ-032 The controller's EXE_MUL path SHALL consume mul_result instead of any combinational multiplier.

Verification
REQ-033 val1=7, val2=6, Is_Mul pulse at T -> freeze=1 during T..T+32, result_valid=1 and mul_result=42 at T+33, freeze=0 at T+33.
REQ-034 val1=32'hFFFFFFFF, val2=2 -> mul_result=32'hFFFFFFFE; val1=32'h80000000, val2=2 -> mul_result=0 (overflow discarded).
REQ-035 Is_Mul held high through BUSY with val1/val2 changed at T+5 -> exactly one result_valid at T+33 carrying the T-latched product.
REQ-036 flush=1 at T+10 -> IDLE at T+11, freeze=0 from T+10, no result_valid within T..T+40, mul_result unchanged.
REQ-037 rst asserted asynchronously at T+15 mid-edge -> freeze=0 and mul_result=0 immediately; a new 3*5 started after release -> 15 after 33 cycles.
REQ-038 Two MULs back-to-back (3*4 at T, 5*5 at T+34) -> result_valid at T+33 (12) and T+67 (25), with freeze=0 only at T+33 and T+67 across the window.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the sequential multiplier: default operand width and FSM state encodings.
package mul_sequencer_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: operand shift registers, accumulator, adder and the held result register.
module mul_shift_add_dp
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             capture,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  // Carries past bit WIDTH-1 are dropped, so the product is modulo 2^WIDTH.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (load) begin
        mcand  <= val1;
        mplier <= val2;
        acc    <= '0;
      end else if (step) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        acc    <= acc_next;
      end
      // The final partial sum goes straight into result, which then holds until the next completion.
      if (capture) begin
        result <= acc_next;
      end
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL sequencer: stalls the pipeline while a WIDTH-step shift-add multiply runs.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Is_Mul,
  input  logic             flush,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             freeze,
  output logic [WIDTH-1:0] mul_result,
  output logic             result_valid
);

  mul_state_t       state;
  logic [CNT_W-1:0] count;
  logic             start;
  logic             step;
  logic             last_step;

  assign start     = (state == IDLE) && Is_Mul && !flush;
  assign step      = (state == BUSY) && !flush;
  assign last_step = step && (count == CNT_W'(WIDTH - 1));

  // Freeze drops in DONE so the pipeline advances on that edge; a flush releases it at once.
  assign freeze = !rst && (start || step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            count <= '0;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
            if (last_step) begin
              state        <= DONE;
              result_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (start),
    .step   (step),
    .capture(last_step),
    .val1   (val1),
    .val2   (val2),
    .result (mul_result)
  );

endmodule
